mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It consumes the execute-stage results (ALU result, forwarded store data, control bits), drives a req/ack data-memory bus with byte enables, aligns and sign-extends load data, and registers everything into the MEM/WB pipeline register. It stalls the pipeline while a bus transaction is outstanding and exports the forwarding value consumed by the execute stage's operand muxes.

## Interface
Parameters:
- none. Widths are fixed: XLEN 32, register address 5.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  execute-stage output holds a real instruction, not a bubble.
- alu_result  in  32  effective address for loads and stores, or the ALU result.
- rs2  in  32  forwarded store data.
- memWrite  in  1  store.
- memRead2  in  1  load.
- mem_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved, treated as word.
- mem_sign  in  1  1 = sign-extend load data; 0 = zero-extend.
- regWrite  in  1  instruction writes the register file.
- rf_wr_sel  in  2  write-back select: 0 pc_plus4, 1 load data, 2 or 3 alu_result.
- wa  in  5  destination register.
- pc_plus4  in  32  link value.
- d_req  out  1  bus request.
- d_we  out  1  1 = write.
- d_addr  out  32  word-aligned address (low 2 bits = 0).
- d_be  out  4  byte enables.
- d_wdata  out  32  store data, lane-replicated.
- d_ack  in  1  transaction complete; d_rdata is valid in the same cycle.
- d_rdata  in  32  read word.
- stall_mem  out  1  freeze the upstream stages and hold the inputs stable.
- mem_wd  out  32  forwarding value for the execute stage: alu_result, or pc_plus4 when rf_wr_sel = 0.
- wb_valid  out  1  registered.
- wb_regWrite  out  1  registered.
- wb_wa  out  5  registered.
- wb_wd  out  32  registered write-back data.
- misalign_err  out  1  registered one-cycle pulse.

## Operation
- mem_op = in_valid & (memWrite | memRead2).
- Misaligned access:
  - half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - No bus request is issued and no stall occurs.
  - The instruction retires as a bubble (wb_regWrite = 0, wb_valid = 1).
  - misalign_err = 1 for one cycle.
- Byte enables by size:
  - byte: 0001 << addr[1:0].
  - half: 0011 << addr[1:0].
  - word: 1111.
- Store data replication:
  - byte: replicated to all 4 lanes.
  - half: replicated to both halves.
- Load data handling:
  - Shift d_rdata right by 8·addr[1:0].
  - Truncate to the access size.
  - Sign- or zero-extend per mem_sign.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - An aligned mem_op drives d_req combinationally from the inputs.
  - If d_ack is seen the same cycle, the access completes and the state stays IDLE.
  - Otherwise the address, be, wdata, we, size, sign, wa, regWrite and addr[1:0] are latched and the FSM moves to WAIT.
- WAIT:
  - d_req and the bus signals are driven from the latched copy.
  - On d_ack the access completes and the FSM returns to IDLE.
  - Inputs are ignored while in WAIT.
- stall_mem = (IDLE & aligned mem_op & !d_ack) | (WAIT & !d_ack).
- MEM/WB register loads every cycle:
  - stall_mem = 1: loads a bubble (wb_valid = 0, wb_regWrite = 0).
  - stall_mem = 0: loads the completing instruction.
  - wb_wd source: aligned load data when rf_wr_sel = 1, pc_plus4 when 0, alu_result otherwise.
  - A completing access from WAIT uses the latched fields.
- A non-memory instruction passes straight through in one cycle with no bus activity.

## Timing
- Reset, synchronous:
  - FSM goes to IDLE.
  - wb_valid, wb_regWrite and misalign_err = 0; wb_wa = 0; wb_wd = 0.
- d_req/d_we/d_be are combinational, so they are 0 while RST is asserted, and RST also drops the latched copy.
- RST during WAIT abandons the transaction: d_req deasserts the same cycle and a later d_ack is ignored in IDLE.
- Latency:
  - Zero-wait access: the WB register is valid on the next edge.
  - N wait cycles: N stall cycles, then WB is valid on the edge after d_ack.
- d_req stays high and the bus signals stay stable until d_ack; the bus must never see them change mid-transaction.
- An ack in the same cycle as request entry is legal.
- d_ack with d_req = 0 is ignored.
- mem_wd is combinational from the current inputs. It is not meaningful for loads; execute-stage hazard logic flushes on load-use.

## Test plan
- ALU passthrough:
  - Stimulus: in_valid = 1, regWrite = 1, rf_wr_sel = 2, alu_result = 0x0000_1234, wa = 5.
  - Response: next cycle wb_wd = 0x1234, wb_wa = 5, wb_regWrite = 1, d_req never high, stall_mem = 0.
- Store byte:
  - Stimulus: alu_result = 0x1003, rs2 = 0x0000_00AB, size 0, d_ack same cycle.
  - Response: d_addr = 0x1000, d_be = 1000, d_wdata = 0xABABABAB, d_we = 1, no stall.
- Signed load half with 2 wait states:
  - Stimulus: addr 0x2002, d_rdata = 0x8001_0000, ack on the 3rd cycle.
  - Response: stall_mem high for 2 cycles, WB bubbles meanwhile, then wb_wd = 0xFFFF_8001; with mem_sign = 0 the same stimulus gives 0x0000_8001.
- Misaligned word:
  - Stimulus: load word at addr 0x3001.
  - Response: no d_req, misalign_err pulses 1 cycle, wb_regWrite = 0, no stall.
- Reset during WAIT:
  - Stimulus: load outstanding, RST asserted for 1 cycle, late d_ack afterwards.
  - Response: d_req = 0 the same cycle, FSM in IDLE, all wb_* = 0, the late ack causes no WB write.
- JAL link:
  - Stimulus: rf_wr_sel = 0, pc_plus4 = 0x104.
  - Response: mem_wd = 0x104 the same cycle, wb_wd = 0x104 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with req/ack data bus, load alignment and MEM/WB register
module mem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2,
    input  logic        memWrite,
    input  logic        memRead2,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic        regWrite,
    input  logic [1:0]  rf_wr_sel,
    input  logic [4:0]  wa,
    input  logic [31:0] pc_plus4,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        stall_mem,
    output logic [31:0] mem_wd,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [4:0]  wb_wa,
    output logic [31:0] wb_wd,
    output logic        misalign_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      st;
    logic [31:0] l_alu, l_wdata;
    logic [3:0]  l_be;
    logic [1:0]  l_size;
    logic [4:0]  l_wa;
    logic        l_we, l_sign, l_rw, l_ld;
    logic        wt, mem_op, mis, go;
    logic [3:0]  be_i;
    logic [31:0] wdata_i, sh, ld_data;
    logic [1:0]  c_off, c_size;
    logic        c_sign;

    assign wt      = st == WAIT;
    assign mem_op  = in_valid & (memWrite | memRead2);
    assign mis     = (mem_size == 2'd1) ? alu_result[0] : mem_size[1] & |alu_result[1:0];
    assign go      = mem_op & ~mis;
    assign be_i    = mem_size[1] ? 4'b1111 : (mem_size[0] ? 4'b0011 : 4'b0001) << alu_result[1:0];
    assign wdata_i = mem_size[1] ? rs2 : mem_size[0] ? {2{rs2[15:0]}} : {4{rs2[7:0]}};

    // While waiting, the bus is driven only from the latched copy so it cannot change mid-transaction
    assign d_req     = ~RST & (wt | go);
    assign d_we      = d_req & (wt ? l_we : memWrite);
    assign d_be      = d_req ? (wt ? l_be : be_i) : 4'b0000;
    assign d_addr    = {(wt ? l_alu[31:2] : alu_result[31:2]), 2'b00};
    assign d_wdata   = wt ? l_wdata : wdata_i;
    assign stall_mem = d_req & ~d_ack;

    assign c_off   = wt ? l_alu[1:0] : alu_result[1:0];
    assign c_size  = wt ? l_size : mem_size;
    assign c_sign  = wt ? l_sign : mem_sign;
    assign sh      = d_rdata >> {c_off, 3'b000};
    assign ld_data = c_size[1] ? sh :
                     c_size[0] ? {{16{c_sign & sh[15]}}, sh[15:0]} : {{24{c_sign & sh[7]}}, sh[7:0]};
    assign mem_wd  = (rf_wr_sel == 2'd0) ? pc_plus4 : alu_result;

    always_ff @(posedge CLK) begin
        if (RST) begin
            st           <= IDLE;
            l_alu        <= '0;
            l_wdata      <= '0;
            l_be         <= '0;
            l_size       <= '0;
            l_wa         <= '0;
            l_we         <= 1'b0;
            l_sign       <= 1'b0;
            l_rw         <= 1'b0;
            l_ld         <= 1'b0;
            wb_valid     <= 1'b0;
            wb_regWrite  <= 1'b0;
            wb_wa        <= '0;
            wb_wd        <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (!wt && go && !d_ack) begin
                st      <= WAIT;
                l_alu   <= alu_result;
                l_wdata <= wdata_i;
                l_be    <= be_i;
                l_size  <= mem_size;
                l_wa    <= wa;
                l_we    <= memWrite;
                l_sign  <= mem_sign;
                l_rw    <= regWrite;
                l_ld    <= rf_wr_sel == 2'd1;
            end else if (wt && d_ack) begin
                st <= IDLE;
            end
            wb_valid     <= ~stall_mem & (wt | in_valid);
            wb_regWrite  <= ~stall_mem & (wt ? l_rw : in_valid & regWrite & ~(mem_op & mis));
            wb_wa        <= stall_mem ? '0 : wt ? l_wa : wa;
            wb_wd        <= stall_mem ? '0 :
                            wt ? (l_ld ? ld_data : l_alu) :
                            (rf_wr_sel == 2'd1) ? ld_data :
                            (rf_wr_sel == 2'd0) ? pc_plus4 : alu_result;
            misalign_err <= ~wt & mem_op & mis;
        end
    end
endmodule
